// File: rtl/timer_device.sv
// timer_device: memory-mapped machine timer (mtime/mtimecmp/ctrl) with a fixed one-cycle bus response.
module timer_device #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 8
) (
    input  logic                    ck_i,
    input  logic                    rst_ni,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [DataWidth/8-1:0]  device_be_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic                    device_rvalid_o,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    device_err_o,
    output logic                    timer_irq_o
);
    logic [63:0]              mtime, mtime_next;
    logic [63:0]              mtimecmp, mtimecmp_next;
    logic                     en, en_next;
    logic [PrescaleWidth-1:0] pre, pre_next, pcnt, pcnt_next;
    logic [2:0]               offset;
    logic                     wr, mapped, tick;
    logic                     wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic [31:0]              ctrl_word, read_mux, rdata_next;
    logic                     unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            merge[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    endfunction

    assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};
    assign offset      = device_addr_i[4:2];
    assign mapped      = offset <= 3'd4;
    assign wr          = device_req_i && device_we_i;
    assign wr_lo       = wr && offset == 3'd0;
    assign wr_hi       = wr && offset == 3'd1;
    assign wr_cmp_lo   = wr && offset == 3'd2;
    assign wr_cmp_hi   = wr && offset == 3'd3;
    assign wr_ctrl     = wr && offset == 3'd4;
    assign ctrl_word   = {{(24-PrescaleWidth){1'b0}}, pre, 7'b0, en};

    always_comb begin
        tick      = en && pcnt == pre;
        pcnt_next = !en ? pcnt : tick ? '0 : pcnt + 1'b1;
        // A write to either mtime word suppresses that cycle's increment.
        mtime_next = wr_lo ? {mtime[63:32], merge(mtime[31:0], device_wdata_i, device_be_i)} :
                     wr_hi ? {merge(mtime[63:32], device_wdata_i, device_be_i), mtime[31:0]} :
                             mtime + {63'd0, tick};
        mtimecmp_next = wr_cmp_lo ? {mtimecmp[63:32], merge(mtimecmp[31:0], device_wdata_i, device_be_i)} :
                        wr_cmp_hi ? {merge(mtimecmp[63:32], device_wdata_i, device_be_i), mtimecmp[31:0]} :
                                    mtimecmp;
        en_next  = wr_ctrl && device_be_i[0] ? device_wdata_i[0] : en;
        pre_next = pre;
        for (int i = 0; i < PrescaleWidth; i++)
            if (wr_ctrl && device_be_i[(8+i)/8]) pre_next[i] = device_wdata_i[8+i];
        read_mux = offset == 3'd0 ? mtime[31:0] :
                   offset == 3'd1 ? mtime[63:32] :
                   offset == 3'd2 ? mtimecmp[31:0] :
                   offset == 3'd3 ? mtimecmp[63:32] :
                   offset == 3'd4 ? ctrl_word : 32'd0;
        rdata_next = device_req_i && !device_we_i && mapped ? read_mux : 32'd0;
    end

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
            device_err_o    <= 1'b0;
            timer_irq_o     <= 1'b0;
            mtime           <= '0;
            mtimecmp        <= '1;
            en              <= 1'b0;
            pre             <= '0;
            pcnt            <= '0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= rdata_next;
            device_err_o    <= device_req_i && !mapped;
            timer_irq_o     <= mtime >= mtimecmp;
            mtime           <= mtime_next;
            mtimecmp        <= mtimecmp_next;
            en              <= en_next;
            pre             <= pre_next;
            pcnt            <= pcnt_next;
        end
    end
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed checks of timer_device register access, counting and interrupt.
module tb_timer_device;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid, err, irq;
    logic [31:0] rdata;
    int          checks = 0;
    int          failures = 0;

    timer_device dut (
        .ck_i(clk), .rst_ni(rst_n), .device_req_i(req), .device_addr_i(addr),
        .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
        .device_rvalid_o(rvalid), .device_rdata_o(rdata), .device_err_o(err),
        .timer_irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic exp_err);
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk({tag, ".rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, ".rdata"}, 64'(rdata), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'(exp_err));
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input logic exp_err);
        req = 1'b1; we = 1'b0; addr = a; be = 4'h0;
        @(negedge clk);
        req = 1'b0;
        chk({tag, ".rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, ".rdata"}, 64'(rdata), 64'(exp));
        chk({tag, ".err"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        // reset state and first reads
        reset_dut();
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.rdata", 64'(rdata), 64'd0);
        chk("rst.irq", 64'(irq), 64'd0);
        rd("rst.mtime_lo", 32'h0, 32'h0, 1'b0);
        rd("rst.cmp_hi", 32'hC, 32'hFFFF_FFFF, 1'b0);
        chk("rst.irq2", 64'(irq), 64'd0);

        // counting with prescale 0 then prescale 3
        wr("w.ctrl1", 32'h10, 4'hF, 32'h0000_0001, 1'b0);
        idle(10);
        rd("cnt.p0", 32'h0, 32'd10, 1'b0);
        wr("w.ctrl3", 32'h10, 4'hF, 32'h0000_0301, 1'b0);
        idle(8);
        rd("cnt.p3a", 32'h0, 32'd14, 1'b0);
        idle(3);
        rd("cnt.p3b", 32'h0, 32'd15, 1'b0);
        rd("ctrl.rd", 32'h10, 32'h0000_0301, 1'b0);

        // low-to-high carry
        reset_dut();
        wr("w.lo", 32'h0, 4'hF, 32'hFFFF_FFFE, 1'b0);
        wr("w.hi", 32'h4, 4'hF, 32'h0, 1'b0);
        wr("w.en", 32'h10, 4'hF, 32'h1, 1'b0);
        idle(1);
        wr("w.dis", 32'h10, 4'hF, 32'h0, 1'b0);
        rd("carry.lo", 32'h0, 32'h0, 1'b0);
        rd("carry.hi", 32'h4, 32'h1, 1'b0);

        // mtime == mtimecmp asserts irq, then 64-bit wrap to zero
        reset_dut();
        wr("w.lo1", 32'h0, 4'hF, 32'hFFFF_FFFF, 1'b0);
        wr("w.hi1", 32'h4, 4'hF, 32'hFFFF_FFFF, 1'b0);
        idle(1);
        chk("eq.irq", 64'(irq), 64'd1);
        wr("w.en2", 32'h10, 4'hF, 32'h1, 1'b0);
        wr("w.dis2", 32'h10, 4'hF, 32'h0, 1'b0);
        rd("wrap.lo", 32'h0, 32'h0, 1'b0);
        rd("wrap.hi", 32'h4, 32'h0, 1'b0);
        chk("wrap.irq", 64'(irq), 64'd0);

        // write colliding with an increment: write wins, no increment
        reset_dut();
        wr("w.lo2", 32'h0, 4'hF, 32'h1122_33FF, 1'b0);
        wr("w.en3", 32'h10, 4'hF, 32'h1, 1'b0);
        wr("w.lo_b0", 32'h0, 4'b0001, 32'h0000_0100, 1'b0);
        rd("coll.lo", 32'h0, 32'h1122_3300, 1'b0);

        // interrupt rise and fall
        reset_dut();
        wr("w.cmplo", 32'h8, 4'hF, 32'd20, 1'b0);
        wr("w.cmphi", 32'hC, 4'hF, 32'd0, 1'b0);
        chk("irq.pre", 64'(irq), 64'd0);
        wr("w.en4", 32'h10, 4'hF, 32'h1, 1'b0);
        idle(20);
        chk("irq.at20", 64'(irq), 64'd0);
        idle(1);
        chk("irq.rise", 64'(irq), 64'd1);
        wr("w.cmp1000", 32'h8, 4'hF, 32'd1000, 1'b0);
        chk("irq.hold", 64'(irq), 64'd1);
        idle(1);
        chk("irq.fall", 64'(irq), 64'd0);
        rd("cmp.rd", 32'h8, 32'd1000, 1'b0);

        // unmapped offsets, reserved ctrl bits, back-to-back reads
        reset_dut();
        wr("w.ctrlres", 32'h10, 4'hF, 32'hFFFF_FFFE, 1'b0);
        rd("ctrl.res", 32'h10, 32'h0000_FF00, 1'b0);
        wr("w.lo3", 32'h0, 4'hF, 32'hA5A5_0001, 1'b0);
        wr("w.hi3", 32'h4, 4'hF, 32'h0000_0002, 1'b0);
        wr("w.cmplo3", 32'h8, 4'hF, 32'h0000_0030, 1'b0);
        wr("w.noop", 32'h8, 4'h0, 32'hDEAD_BEEF, 1'b0);
        rd("unm.rd5", 32'h14, 32'h0, 1'b1);
        wr("unm.wr7", 32'h1C, 4'hF, 32'h1234_5678, 1'b1);
        rd("b2b.0", 32'hFFFF_FFE3, 32'hA5A5_0001, 1'b0);
        rd("b2b.1", 32'h4, 32'h0000_0002, 1'b0);
        rd("b2b.2", 32'h8, 32'h0000_0030, 1'b0);
        idle(1);
        chk("idle.rvalid", 64'(rvalid), 64'd0);
        chk("idle.rdata", 64'(rdata), 64'd0);
        chk("idle.err", 64'(err), 64'd0);
        rd("unm.cmphi", 32'hC, 32'hFFFF_FFFF, 1'b0);

        // reset during a request drops the response
        req = 1'b1; we = 1'b0; addr = 32'h0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0;
        chk("rstmid.rvalid0", 64'(rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid.rvalid1", 64'(rvalid), 64'd0);
        @(negedge clk);
        chk("rstmid.rvalid2", 64'(rvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped machine-timer responder for the simple host/device bus.
- Sits on one bus device port and serves the core's loads and stores to a 64-bit free-running mtime counter, a 64-bit mtimecmp compare register and a control register.
- Drives a level timer interrupt to the core.
- Obeys the bus device contract: always accepts a request and responds exactly one cycle later.

Parameters:
- DataWidth, 32, bus data width; only 32 is supported.
- AddressWidth, 32, bus address width.
- PrescaleWidth, 8, width of the prescaler compare field and counter.

Ports:
- ck_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- device_req_i  input  1  request valid.
- device_addr_i  input  AddressWidth  byte address. Only bits [4:2] are decoded.
- device_we_i  input  1  1 = write, 0 = read.
- device_be_i  input  DataWidth/8  byte enables, used for writes.
- device_wdata_i  input  DataWidth  write data.
- device_rvalid_o  output  1  response valid, one cycle after the request.
- device_rdata_o  output  DataWidth  read data, valid with rvalid.
- device_err_o  output  1  error response, valid with rvalid.
- timer_irq_o  output  1  machine timer interrupt, level.

Behaviour:

Reset (rst_ni low, asynchronous):
- rvalid=0, rdata=0, err=0, irq=0.
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
- ctrl=0, prescale counter=0.
- Reset asserted mid-transaction drops the pending response; no rvalid follows the deassertion of reset.

Register map (offset = addr[4:2]):
- 0 mtime[31:0]
- 1 mtime[63:32]
- 2 mtimecmp[31:0]
- 3 mtimecmp[63:32]
- 4 ctrl: bit0 = enable, bits[8+PrescaleWidth-1:8] = prescale value; all other bits read 0.
- 5-7: unmapped.
- addr[1:0] and bits above [4] are ignored.

Handshake:
- No grant signal; every cycle with req=1 is accepted.
- Back-to-back requests on consecutive cycles are supported, one response per request.
- Response register: cycle N has req=1, so cycle N+1 has rvalid=1.
- When rvalid=0, rdata=0 and err=0.
- Reads return the register value at the end of cycle N, before any same-cycle update.
- Writes also produce rvalid in cycle N+1, with rdata=0.
- Unmapped offset: err=1, rdata=0 in cycle N+1; writes to unmapped offsets are discarded.

Writes:
- The write takes effect at the clock edge ending cycle N.
- Only bytes with be=1 are updated; be=0 for all bytes is a legal no-op that still responds.
- Writes to ctrl reserved bits are ignored.

Counting:
- When enable=1, the prescale counter increments each cycle.
- When the counter equals the prescale value, it returns to 0 and mtime increments by 1 in the same cycle.
- prescale value 0 means mtime increments every cycle.
- enable=0 freezes both the counter and mtime.
- mtime wraps from 2^64-1 to 0; the carry propagates from the low word to the high word within one cycle.
- A write to ctrl that changes the prescale value does not reset the counter.
- If the counter is greater than the new value, it continues counting up, wraps at 2^PrescaleWidth, then matches.

Simultaneous events:
- If mtime_lo or mtime_hi is written in a cycle where an increment would occur, the write wins.
- In that cycle mtime does not increment: the written bytes take the write data and all other bytes keep their pre-write value.
- The prescale counter still advances normally.

Interrupt:
- timer_irq_o is registered: timer_irq_o <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on current register values.
- The interrupt is independent of enable.
- It deasserts one cycle after mtimecmp is written above mtime.

Test Plan:
1. Reset then read offset 0 at cycle N -> rvalid=1, rdata=0, err=0 at N+1. Read offset 3 -> rdata=32'hFFFF_FFFF. timer_irq_o=0.
2. Write ctrl=32'h0000_0001 (enable, prescale 0), wait 10 cycles, read mtime_lo -> value is 10 ± the fixed pipeline offset, checked by the model. Write ctrl prescale=3 -> mtime advances once per 4 cycles.
3. Write mtime_lo=32'hFFFF_FFFE and mtime_hi=0, prescale 0 -> after 2 increments mtime_hi=1 and mtime_lo=0.
4. Enable counting, then write mtime_lo=32'h0000_0100 with be=4'b0001 in a cycle where an increment would occur -> byte 0 = 8'h00, upper bytes unchanged from their pre-write value, no increment that cycle.
5. Set mtimecmp={0, 32'd20}, prescale 0, enable -> timer_irq_o rises one cycle after mtime reaches 20. Write mtimecmp_lo=32'd1000 -> irq falls in the following cycle.
6. Read offset 5, write offset 7, then back-to-back reads at offsets 0/1/2 on consecutive cycles:
   - offsets 5 and 7 -> err=1, rdata=0, no register changes;
   - the three reads -> three consecutive rvalid cycles with matching data.
   - Assert rst_ni low in a cycle with req=1 -> no rvalid after reset release.
